// File: rtl/scu_int_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scu_int_ctrl_pkg : SCU interrupt register types, masks and level tables. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package scu_int_ctrl_pkg;

  typedef struct packed {
    logic        ext_mask;
    logic        rsvd;
    logic [13:0] int_mask;
  } ims_t;

  typedef struct packed {
    logic [15:0] eis;
    logic [1:0]  rsvd;
    logic [13:0] int_st;
  } ist_t;

  typedef logic aiack_t;

  localparam logic [15:0] IMS_INIT  = 16'hBFFF;
  localparam logic [15:0] IMS_WMASK = 16'hBFFF;
  localparam logic [31:0] IST_WMASK = 32'hFFFF_3FFF;
  localparam aiack_t      AIACK_INIT  = 1'b0;
  localparam aiack_t      AIACK_WMASK = 1'b1;

  typedef enum logic [3:0] {
    SRC_VBII  = 4'd0,
    SRC_VBOI  = 4'd1,
    SRC_HBII  = 4'd2,
    SRC_TM0I  = 4'd3,
    SRC_TM1I  = 4'd4,
    SRC_DSPI  = 4'd5,
    SRC_SNDI  = 4'd6,
    SRC_SMPI  = 4'd7,
    SRC_PADI  = 4'd8,
    SRC_DMA2I = 4'd9,
    SRC_DMA1I = 4'd10,
    SRC_DMA0I = 4'd11,
    SRC_DMAII = 4'd12,
    SRC_SDEI  = 4'd13
  } int_src_e;

  // Index 0 sits in the least significant nibble.
  localparam logic [13:0][3:0] INT_LEVEL = {
    4'h2, 4'h3, 4'h5, 4'h6, 4'h6, 4'h8, 4'h8,
    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
  };

  localparam logic [15:0][3:0] EXT_LEVEL = {
    {8{4'h1}}, {4{4'h4}}, {4{4'h7}}
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/scu_int_prio.sv
// ---------------------------------------------------------------------------
// scu_int_prio : combinational IRL priority encoder over IST/EIS. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scu_int_prio
  import scu_int_ctrl_pkg::*;
(
  input  logic [13:0] i_ist_int,
  input  logic [13:0] i_int_mask,
  input  logic        i_ext_mask,
  input  logic [15:0] i_eis,
  output logic [3:0]  o_level,
  output logic [3:0]  o_idx,
  output logic        o_is_ext
);

  logic [3:0] w_best_level;
  logic [3:0] w_best_idx;
  logic       w_best_ext;

  // Strict '>' while scanning upward keeps the lowest vector on ties.
  always_comb begin
    w_best_level = 4'h0;
    w_best_idx   = 4'h0;
    w_best_ext   = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (i_ist_int[n] && !i_int_mask[n] && (INT_LEVEL[n] > w_best_level)) begin
        w_best_level = INT_LEVEL[n];
        w_best_idx   = 4'(n);
        w_best_ext   = 1'b0;
      end
    end
    for (int n = 0; n < 16; n++) begin
      if (i_eis[n] && !i_ext_mask && (EXT_LEVEL[n] > w_best_level)) begin
        w_best_level = EXT_LEVEL[n];
        w_best_idx   = 4'(n);
        w_best_ext   = 1'b1;
      end
    end
  end

  assign o_level  = w_best_level;
  assign o_idx    = w_best_idx;
  assign o_is_ext = w_best_ext;

endmodule

`default_nettype wire

// File: rtl/scu_int_ctrl.sv
// ---------------------------------------------------------------------------
// scu_int_ctrl : SCU interrupt latch, mask, IRL drive and SH-2 vector handshake. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scu_int_ctrl
  import scu_int_ctrl_pkg::*;
#(
  parameter logic [7:0] VEC_BASE     = 8'h40,
  parameter logic [7:0] EXT_VEC_BASE = 8'h50
)(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [13:0] INT_SRC,
  input  logic [15:0] EXT_INT_N,
  input  logic [31:0] REG_DI,
  input  logic        IMS_WE,
  input  logic        IST_WE,
  input  logic        AIACK_WE,
  output logic [15:0] IMS_Q,
  output logic [31:0] IST_Q,
  output logic        AIACK_Q,
  output logic [3:0]  IRL_N,
  input  logic        IVECF,
  output logic [7:0]  VEC,
  output logic        VEC_VLD
);

  ims_t       ims_q, ims_d;
  ist_t       ist_q, ist_d;
  aiack_t     aiack_q, aiack_d;
  logic [3:0] irl_q, irl_d;
  logic [3:0] idx_q, idx_d;
  logic       ext_q, ext_d;
  logic [7:0] vec_q, vec_d;
  logic       vec_vld_q, vec_vld_d;
  state_e     state_q, state_d;

  logic [3:0]  w_win_level;
  logic [3:0]  w_win_idx;
  logic        w_win_ext;
  logic [15:0] w_eis_gated;
  logic [31:0] w_ist_keep;
  logic [31:0] w_ist_set;

  // Pending EIS bits only compete while the A-bus acknowledge is enabled.
  assign w_eis_gated = ist_q.eis & {16{aiack_q}};

  scu_int_prio u_prio (
    .i_ist_int  (ist_q.int_st),
    .i_int_mask (ims_q.int_mask),
    .i_ext_mask (ims_q.ext_mask),
    .i_eis      (w_eis_gated),
    .o_level    (w_win_level),
    .o_idx      (w_win_idx),
    .o_is_ext   (w_win_ext)
  );

  always_comb begin
    ims_d     = ims_q;
    aiack_d   = aiack_q;
    irl_d     = irl_q;
    idx_d     = idx_q;
    ext_d     = ext_q;
    vec_d     = vec_q;
    vec_vld_d = 1'b0;
    state_d   = state_q;
    w_ist_keep = IST_WE ? (REG_DI & IST_WMASK) : 32'hFFFF_FFFF;
    w_ist_set  = {~EXT_INT_N & {16{aiack_q}}, 2'b00, INT_SRC};

    case (state_q)
      ST_IDLE: begin
        if (IVECF) begin
          state_d = ST_ACK;
        end else begin
          irl_d = w_win_level;
          idx_d = w_win_idx;
          ext_d = w_win_ext;
        end
      end
      ST_ACK: begin
        state_d   = ST_IDLE;
        vec_vld_d = 1'b1;
        // IRL drops for one cycle so the serviced level is never re-presented.
        irl_d     = 4'h0;
        if (irl_q == 4'h0) begin
          vec_d = 8'h00;
        end else begin
          w_ist_keep[{ext_q, idx_q}] = 1'b0;
          if (ext_q) begin
            vec_d   = EXT_VEC_BASE + {4'h0, idx_q};
            aiack_d = 1'b0;
          end else begin
            vec_d   = VEC_BASE + {4'h0, idx_q};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (IMS_WE)   ims_d   = ims_t'(REG_DI[15:0] & IMS_WMASK);
    if (AIACK_WE) aiack_d = REG_DI[0] & AIACK_WMASK;
    ist_d = ist_t'(((ist_q & w_ist_keep) | w_ist_set) & IST_WMASK);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ims_q     <= ims_t'(IMS_INIT);
      ist_q     <= '0;
      aiack_q   <= AIACK_INIT;
      irl_q     <= 4'h0;
      idx_q     <= 4'h0;
      ext_q     <= 1'b0;
      vec_q     <= 8'h00;
      vec_vld_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else if (CE) begin
      ims_q     <= ims_d;
      ist_q     <= ist_d;
      aiack_q   <= aiack_d;
      irl_q     <= irl_d;
      idx_q     <= idx_d;
      ext_q     <= ext_d;
      vec_q     <= vec_d;
      vec_vld_q <= vec_vld_d;
      state_q   <= state_d;
    end
  end

  assign IMS_Q   = ims_q;
  assign IST_Q   = ist_q;
  assign AIACK_Q = aiack_q;
  assign IRL_N   = ~irl_q;
  assign VEC     = vec_q;
  assign VEC_VLD = vec_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_scu_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scu_int_ctrl : scoreboard bench for the SCU interrupt controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_scu_int_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic [13:0] INT_SRC;
  logic [15:0] EXT_INT_N;
  logic [31:0] REG_DI;
  logic        IMS_WE, IST_WE, AIACK_WE;
  logic [15:0] IMS_Q;
  logic [31:0] IST_Q;
  logic        AIACK_Q;
  logic [3:0]  IRL_N;
  logic        IVECF;
  logic [7:0]  VEC;
  logic        VEC_VLD;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  logic [7:0] exp_q[$];

  scu_int_ctrl #(.VEC_BASE(8'h40), .EXT_VEC_BASE(8'h50)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .INT_SRC(INT_SRC), .EXT_INT_N(EXT_INT_N),
    .REG_DI(REG_DI), .IMS_WE(IMS_WE), .IST_WE(IST_WE), .AIACK_WE(AIACK_WE),
    .IMS_Q(IMS_Q), .IST_Q(IST_Q), .AIACK_Q(AIACK_Q), .IRL_N(IRL_N),
    .IVECF(IVECF), .VEC(VEC), .VEC_VLD(VEC_VLD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every vector strobe must match the oldest expected vector.
  always @(negedge CLK) begin
    if (VEC_VLD === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("vec_vld_unexpected", {31'b0, VEC_VLD}, 32'h0);
      end else begin
        check("vec", {24'b0, VEC}, {24'b0, exp_q.pop_front()});
      end
      pops++;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic reg_write(input int which, input logic [31:0] di);
    REG_DI = di;
    IMS_WE = (which == 0);
    IST_WE = (which == 1);
    AIACK_WE = (which == 2);
    cyc();
    IMS_WE = 1'b0; IST_WE = 1'b0; AIACK_WE = 1'b0; REG_DI = '0;
  endtask

  task automatic pulse_src(input logic [13:0] src);
    INT_SRC = src;
    cyc();
    INT_SRC = '0;
  endtask

  // Fetch handshake; the ack_* inputs are driven during the vector cycle.
  task automatic fetch(input logic [7:0] exp, input logic ack_we,
                       input logic [31:0] ack_di, input logic [13:0] ack_src);
    int target;
    target = pops + 1;
    exp_q.push_back(exp);
    IVECF = 1'b1;
    cyc();
    IVECF = 1'b0;
    IST_WE = ack_we; REG_DI = ack_di; INT_SRC = ack_src;
    cyc();
    IST_WE = 1'b0; REG_DI = '0; INT_SRC = '0;
    for (int i = 0; i < 8 && pops < target; i++) cyc();
    if (pops < target) check("fetch_timeout", pops, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; CE = 1'b1; INT_SRC = '0; EXT_INT_N = '1; REG_DI = '0;
    IMS_WE = 1'b0; IST_WE = 1'b0; AIACK_WE = 1'b0; IVECF = 1'b0;
    cyc(); cyc();
    check("rst_ims", IMS_Q, 32'hBFFF);
    check("rst_ist", IST_Q, 32'h0);
    check("rst_aiack", AIACK_Q, 32'h0);
    check("rst_irl", IRL_N, 32'hF);
    check("rst_vec", {VEC_VLD, VEC}, 32'h0);
    RST_N = 1'b1;
    cyc();

    // Single internal source, level F.
    reg_write(0, 32'h0000_BFFE);
    check("ims_wr", IMS_Q, 32'hBFFE);
    pulse_src(14'h0001);
    check("ist0_set", IST_Q, 32'h1);
    check("irl_lag", IRL_N, 32'hF);
    cyc();
    check("irl_lvlF", IRL_N, 32'h0);
    fetch(8'h40, 1'b0, '0, '0);
    check("ist0_clr", IST_Q, 32'h0);
    check("irl_idle", IRL_N, 32'hF);
    check("vec_hold", {VEC_VLD, VEC}, 32'h40);

    // Tie at level 8: lower vector first.
    reg_write(0, 32'h0000_0000);
    check("ims_mask", IMS_Q, 32'h0);
    pulse_src(14'h0180);
    cyc();
    check("irl_lvl8", IRL_N, 32'h7);
    fetch(8'h47, 1'b0, '0, '0);
    check("irl_lvl8_b", IRL_N, 32'h7);
    fetch(8'h48, 1'b0, '0, '0);
    check("ist_tie_done", IST_Q, 32'h0);

    // Pulses while CE=0 are lost.
    CE = 1'b0; INT_SRC = 14'h0020;
    cyc();
    INT_SRC = '0; CE = 1'b1;
    cyc();
    check("ce_lost", IST_Q, 32'h0);

    // External source gated by AIACK.
    EXT_INT_N = 16'hFFFB;
    cyc(); cyc();
    check("eis_gated", IST_Q, 32'h0);
    reg_write(2, 32'hFFFF_FFFF);
    check("aiack_set", AIACK_Q, 32'h1);
    cyc();
    check("eis2_set", IST_Q, 32'h0004_0000);
    cyc();
    check("irl_ext7", IRL_N, 32'h8);
    EXT_INT_N = '1;
    fetch(8'h52, 1'b0, '0, '0);
    check("aiack_clr", AIACK_Q, 32'h0);
    check("eis2_clr", IST_Q, 32'h0);

    // CPU clear and source set on the same bit: set wins.
    IST_WE = 1'b1; REG_DI = 32'hFFFF_FFFE; INT_SRC = 14'h0001;
    cyc();
    IST_WE = 1'b0; REG_DI = '0; INT_SRC = '0;
    check("set_wins_cpu", IST_Q, 32'h1);
    reg_write(1, 32'hFFFF_FFFE);
    check("w0c", IST_Q, 32'h0);
    cyc();
    check("irl_none", IRL_N, 32'hF);

    // Spurious fetch with a masked pending bit.
    reg_write(0, 32'h0000_FFFF);
    check("ims_wmask", IMS_Q, 32'hBFFF);
    pulse_src(14'h0010);
    cyc();
    check("irl_masked", IRL_N, 32'hF);
    fetch(8'h00, 1'b0, '0, '0);
    check("spur_ist", IST_Q, 32'h10);
    reg_write(1, 32'hFFFF_FFEF);
    reg_write(0, 32'h0);

    // Race: CPU clears the winner during the vector cycle.
    pulse_src(14'h0002);
    cyc();
    check("irl_lvlE", IRL_N, 32'h1);
    fetch(8'h41, 1'b1, 32'hFFFF_FFFD, '0);
    check("race_ist", IST_Q, 32'h0);

    // Vector-cycle clear vs new pulse on the same bit: bit stays pending.
    pulse_src(14'h0004);
    cyc();
    check("irl_lvlD", IRL_N, 32'h2);
    fetch(8'h42, 1'b0, '0, 14'h0004);
    check("set_wins_vec", IST_Q, 32'h4);
    fetch(8'h42, 1'b0, '0, '0);
    check("ist2_clr", IST_Q, 32'h0);

    // Reset in the middle of a handshake.
    pulse_src(14'h0008);
    cyc();
    check("irl_lvlC", IRL_N, 32'h3);
    IVECF = 1'b1;
    cyc();
    IVECF = 1'b0;
    RST_N = 1'b0;
    #1;
    check("mid_rst_ist", IST_Q, 32'h0);
    check("mid_rst_ims", IMS_Q, 32'hBFFF);
    check("mid_rst_irl", IRL_N, 32'hF);
    repeat (3) cyc();
    RST_N = 1'b1;
    repeat (4) cyc();
    check("mid_rst_vec", {VEC_VLD, VEC}, 32'h0);
    check("sb_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scu_int_ctrl.md
Name: scu_int_ctrl

Overview:
- SCU interrupt controller. Consumes the CPU-written IMS/IST/AIACK register state and acts on it.
- Latches 14 internal interrupt sources and 16 A-bus external lines into IST, applies the IMS mask, and drives the prioritised IRL level to the master SH-2.
- Answers the SH-2 vector-fetch handshake with a vector, and clears the serviced IST bit.
- Sits between the SCU register file (register writes in, read-back out) and the SH-2 interrupt pins.

Parameters:
- VEC_BASE, 8'h40: vector of internal source 0; internal source n returns VEC_BASE+n.
- EXT_VEC_BASE, 8'h50: vector of external source 0; external source n returns EXT_VEC_BASE+n.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all state advances only when CE=1
- INT_SRC  in  14  internal source pulses, 1 CE-cycle wide, bit order as IST[13:0] (VBII..SDEI)
- EXT_INT_N  in  16  A-bus external interrupt lines, active low, level
- REG_DI  in  32  register write data
- IMS_WE  in  1  write strobe for IMS
- IST_WE  in  1  write strobe for IST
- AIACK_WE  in  1  write strobe for AIACK
- IMS_Q  out  16  IMS value, bit 14 always 0
- IST_Q  out  32  IST read-back: EIS in [31:16], internal bits in [13:0], [15:14]=0
- AIACK_Q  out  1  A-bus interrupt acknowledge enable
- IRL_N  out  4  SH-2 interrupt level, active low (4'hF = none)
- IVECF  in  1  SH-2 vector-fetch request pulse
- VEC  out  8  vector number
- VEC_VLD  out  1  VEC valid strobe, 1 CE-cycle

Behaviour:
- Reset: IMS=16'hBFFF, IST=0, AIACK=0, IRL_N=4'hF, VEC=0, VEC_VLD=0, FSM=IDLE.
- IST set: INT_SRC[n]=1 sets IST[n]. EXT_INT_N[n]=0 sets EIS[n], only while AIACK=1.
- IST clear (IST_WE): IST &= REG_DI & 32'hFFFF3FFF (write-0-to-clear). A set and a clear on the same bit in the same cycle: set wins.
- IMS and AIACK writes are masked by 16'hBFFF and 1'b1 respectively.
- Enable rule: internal bit n is enabled when ~IMS[n]. All external bits are enabled when ~IMS[15].
- Fixed levels:
  - internal 0..13 = F,E,D,C,B,A,9,8,8,6,6,5,3,2
  - external 0-3 = 7, 4-7 = 4, 8-15 = 1
- Winner: highest level among pending enabled bits. Ties go to the lowest vector number (internal before external).
- Priority encode is registered: IRL_N reflects IST/IMS one CE-cycle after the change. The winner index is latched alongside IRL.
- FSM states and transitions:
  - IDLE: IRL_N tracks the winner; IVECF -> ACK.
  - ACK: IRL_N and the latched index are frozen. Next CE cycle: VEC=vector(latched index), VEC_VLD=1, clear that IST bit; if external, also clear AIACK. -> IDLE.
  - IVECF ignored outside IDLE.
- Spurious fetch: IVECF while IRL_N=F returns VEC=8'h00 with VEC_VLD=1 and clears nothing.
- Race: the winner bit is cleared by a CPU write between IVECF and the vector cycle -> still return the latched vector; the clear is a no-op.
- Vector-cycle clear vs new INT_SRC on the same bit in the same cycle: set wins; the bit stays pending.
- VEC holds its last value after VEC_VLD drops.
- CE=0: no state change; pulses arriving then are lost. Source blocks must align their pulses to CE.
- Reset asserted mid-handshake: immediate return to reset values, no vector issued.

Decomposition:
- Add to the shared SCU package:
  - IMS/IST/AIACK struct types, masks and init values
  - internal source index enum (VBII=0..SDEI=13)
  - level table constant (14x4 internal, 16x4 external)
- One sub-module: scu_int_prio. Purely combinational: IST, IMS and AIACK-gated EIS in, winner level/index/is_ext out. This keeps the encoder unit-testable.
- FSM, registers and handshake stay in scu_int_ctrl.

Test Plan:
- Reset, then pulse INT_SRC[0] with IMS=16'hBFFE -> IRL_N=4'h0 (level F) one CE later. IVECF -> next cycle VEC=8'h40, VEC_VLD=1, IST[0]=0, IRL_N=4'hF.
- Pulse INT_SRC[7] and INT_SRC[8] together (both level 8), IMS=0 -> first fetch VEC=8'h47, second fetch VEC=8'h48.
- AIACK=0, EXT_INT_N[2]=0 -> EIS unchanged. Write AIACK=1 -> EIS[2]=1, IRL_N=~4'h7. Fetch -> VEC=8'h52, AIACK_Q=0.
- IST_WE with REG_DI=32'hFFFFFFFE in the same cycle as INT_SRC[0] pulse -> IST[0] remains 1.
- IVECF with IRL_N=4'hF -> VEC=8'h00, VEC_VLD=1, IST unchanged.
- INT_SRC[3] pending, IVECF, then RST_N low before the vector cycle -> VEC_VLD never asserts, IST=0, IMS=16'hBFFF.
